// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction sequencer for the YPC core.
// Walks each instruction through fetch, decode, execute, optional memory access
// and writeback. Owns the PC, IR, register-file write strobe, halt and bus-timeout error.
module core_seq_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h8000_0000),
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  input  logic                  ifu_rsp_valid,
  input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
  output logic [DATA_WIDTH-1:0] ir,
  input  logic [6:0]            opcode7,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] pc_next,
  output logic                  lsu_req_valid,
  input  logic                  lsu_req_ready,
  input  logic                  lsu_rsp_valid,
  output logic                  rf_wen,
  output logic                  halt,
  output logic                  err,
  output logic [3:0]            state
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [DATA_WIDTH-1:0] INST_EBREAK = DATA_WIDTH'(32'h0010_0073);

  typedef enum logic [3:0] {
    S_FETCH_REQ  = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_MEM_REQ    = 4'd4,
    S_MEM_WAIT   = 4'd5,
    S_WB         = 4'd6,
    S_HALT       = 4'd7,
    S_ERR        = 4'd8
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_ifu_req_valid;
  logic                  r_lsu_req_valid;
  logic                  r_rf_wen;
  logic                  r_halt;
  logic                  r_err;

  state_t                w_state_nxt;
  logic                  w_bus_wait;
  logic                  w_timeout;
  logic                  w_writes_rd;
  logic [6:0]            w_ir_op;

  assign w_ir_op    = r_ir[6:0];
  assign w_bus_wait = (r_state == S_FETCH_REQ) || (r_state == S_FETCH_WAIT) ||
                      (r_state == S_MEM_REQ)   || (r_state == S_MEM_WAIT);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT));
  assign w_writes_rd = (w_ir_op != OP_STORE) && (w_ir_op != OP_BRANCH) &&
                       (w_ir_op != OP_FENCE) && (r_ir[11:7] != 5'd0);

  // Next-state selection; a completed handshake takes priority over timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH_REQ: begin
        if (r_ifu_req_valid && ifu_req_ready) w_state_nxt = S_FETCH_WAIT;
        else if (w_timeout)                   w_state_nxt = S_ERR;
      end
      S_FETCH_WAIT: begin
        if (ifu_rsp_valid)  w_state_nxt = S_DECODE;
        else if (w_timeout) w_state_nxt = S_ERR;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (r_ir == INST_EBREAK)                          w_state_nxt = S_HALT;
        else if ((opcode7 == OP_LOAD) || (opcode7 == OP_STORE)) w_state_nxt = S_MEM_REQ;
        else                                              w_state_nxt = S_WB;
      end
      S_MEM_REQ: begin
        if (r_lsu_req_valid && lsu_req_ready) w_state_nxt = S_MEM_WAIT;
        else if (w_timeout)                   w_state_nxt = S_ERR;
      end
      S_MEM_WAIT: begin
        if (lsu_rsp_valid)  w_state_nxt = S_WB;
        else if (w_timeout) w_state_nxt = S_ERR;
      end
      S_WB:    w_state_nxt = S_FETCH_REQ;
      S_HALT:  w_state_nxt = S_HALT;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_ERR;
    endcase
  end

  // State, datapath registers and registered outputs derived from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_FETCH_REQ;
      r_cnt           <= '0;
      r_ir            <= '0;
      r_pc            <= RESET_PC;
      r_ifu_req_valid <= 1'b0;
      r_lsu_req_valid <= 1'b0;
      r_rf_wen        <= 1'b0;
      r_halt          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_bus_wait)        r_cnt <= r_cnt + CNT_W'(1);
      else                        r_cnt <= '0;

      if ((r_state == S_FETCH_WAIT) && ifu_rsp_valid) r_ir <= ifu_rsp_data;
      if (r_state == S_WB)                             r_pc <= pc_next;

      r_ifu_req_valid <= (w_state_nxt == S_FETCH_REQ);
      r_lsu_req_valid <= (w_state_nxt == S_MEM_REQ);
      r_rf_wen        <= (w_state_nxt == S_WB) && w_writes_rd;
      r_halt          <= (w_state_nxt == S_HALT);
      r_err           <= (w_state_nxt == S_ERR);
    end
  end

  assign ifu_req_valid = r_ifu_req_valid;
  assign lsu_req_valid = r_lsu_req_valid;
  assign ir            = r_ir;
  assign pc            = r_pc;
  assign rf_wen        = r_rf_wen;
  assign halt          = r_halt;
  assign err           = r_err;
  assign state         = r_state;

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the YPC core.
- Issues instruction fetches and latches the instruction word into an instruction register (IR) that feeds the decode unit.
- Steps each instruction through decode, execute, optional memory access and writeback.
- Owns the PC register, the register-file write strobe, the halt flag and a bus-timeout error flag.

Parameters:
- DATA_WIDTH, 32: instruction, PC and data width.
- RESET_PC, 32'h8000_0000: PC value after reset.
- TIMEOUT, 255: maximum wait cycles in any bus-wait state before ERR; 8-bit counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-low.
- ifu_req_valid  out  1  fetch request valid; address is pc.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_data  in  DATA_WIDTH  fetched instruction.
- ir  out  DATA_WIDTH  instruction register, drives decode.
- opcode7  in  7  opcode from decode (ir[6:0]).
- pc  out  DATA_WIDTH  current PC.
- pc_next  in  DATA_WIDTH  next PC from execute.
- lsu_req_valid  out  1  load/store request valid.
- lsu_req_ready  in  1  load/store request accepted.
- lsu_rsp_valid  in  1  load data returned / store completed.
- rf_wen  out  1  register-file write strobe.
- halt  out  1  ebreak retired.
- err  out  1  bus timeout occurred.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH_REQ, pc=RESET_PC, ir=0, timeout counter=0.
  - rf_wen=0, halt=0, err=0, ifu_req_valid=0, lsu_req_valid=0.
  - Deassertion is sampled on clk; request outputs assert from the first clock edge after release.
- State encodings: FETCH_REQ=0, FETCH_WAIT=1, DECODE=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, HALT=7, ERR=8.
- ifu_req_valid=1 only in FETCH_REQ. lsu_req_valid=1 only in MEM_REQ. All outputs are registered or decoded from state.
- Handshakes:
  - A request completes on a cycle where valid&ready=1.
  - Valid is held high until accepted.
  - A response is accepted only in the matching WAIT state; a response arriving in any other state is ignored.
- Transitions:
  - FETCH_REQ -> FETCH_WAIT on ifu_req_ready.
  - FETCH_WAIT -> DECODE on ifu_rsp_valid; ir <= ifu_rsp_data in the same edge.
  - DECODE -> EXEC, unconditionally after 1 cycle.
  - EXEC:
    - ir==32'h0010_0073 (ebreak) -> HALT.
    - opcode7==7'b0000011 (load) or 7'b0100011 (store) -> MEM_REQ.
    - otherwise -> WB.
  - MEM_REQ -> MEM_WAIT on lsu_req_ready.
  - MEM_WAIT -> WB on lsu_rsp_valid.
  - WB -> FETCH_REQ; pc <= pc_next at the same edge.
  - HALT: terminal, halt=1; only reset exits.
  - ERR: terminal, err=1; only reset exits.
- rf_wen:
  - 1-cycle pulse in WB only.
  - Suppressed for store (0100011), branch (1100011), fence (0001111) and rd==ir[11:7]==0.
- Timeout counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT.
  - Reaching TIMEOUT -> ERR on the next edge. Handshake completion in the same cycle wins over timeout.
- Latency, single-cycle-ready memory with response one cycle after accept:
  - ALU instruction: 5 cycles, FETCH_REQ through WB.
  - Load/store: 7 cycles.
- Asynchronous reset mid-instruction (any state) aborts it: no rf_wen, pc=RESET_PC, outstanding bus responses ignored.

Test Plan:
- Reset then ALU stream: release rst, ready=1, rsp 1 cycle later with inst 32'h0010_0093 (addi x1,x0,1), pc_next=pc+4 -> rf_wen pulses in cycle 5; pc goes 8000_0000 -> 8000_0004; state sequence 0,1,2,3,6.
- Load with delayed memory: inst 32'h0000_2103 (lw x2,0(x0)), lsu_req_ready low for 3 cycles, rsp after 2 more -> lsu_req_valid held 4 cycles; rf_wen once in WB; 12 cycles total.
- Store and rd=0: sw 32'h0020_2023 -> no rf_wen. addi x0 32'h0000_0013 -> no rf_wen. pc still advances both times.
- Ebreak: fetch 32'h0010_0073 -> HALT after EXEC; halt=1; ifu_req_valid stays 0 for 20 further cycles; pc unchanged.
- Timeout: hold ifu_req_ready=0 -> err=1 and state=8 after 255 cycles. Separately, ready asserted exactly at count 255 -> FETCH_WAIT, no error.
- Reset mid-MEM_WAIT: assert rst low asynchronously between edges -> outputs reset immediately; late lsu_rsp_valid ignored; fetch restarts at 8000_0000.
